// File: rtl/io_bus_fabric_if.sv
// io_bus_fabric_if: KCPSM6 port bus between the micro wrapper (master) and the I/O fabric (slave).
interface io_bus_fabric_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] port_id;
  logic [DATA_W-1:0] out_port;
  logic              write_strobe;
  logic              read_strobe;
  logic [DATA_W-1:0] in_port;
  logic              interrupt;
  logic              interrupt_ack;
  modport master (output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
                  input in_port, interrupt);
  modport slave  (input port_id, out_port, write_strobe, read_strobe, interrupt_ack,
                  output in_port, interrupt);
endinterface

// File: rtl/io_bus_fabric.sv
// io_bus_fabric: port_id decode, registered read mux and prioritised maskable interrupt.
// Define IO_FABRIC_RDPULSE_EN to generate per-channel read strobes on ch_rd.
module io_bus_fabric #(
  parameter int              N_PERIPH  = 4,
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter int              SHIFT     = 4,
  parameter logic [ADDR_W-1:0] CTRL_BASE = 8'hF0
) (
  input  logic                       clk,
  input  logic                       reset,
  io_bus_fabric_if.slave             bus,
  output logic [SHIFT-1:0]           ch_addr,
  output logic [N_PERIPH-1:0]        ch_wr,
  output logic [N_PERIPH-1:0]        ch_rd,
  input  logic [N_PERIPH*DATA_W-1:0] ch_rdata,
  input  logic [N_PERIPH-1:0]        ch_irq
);
  logic [N_PERIPH-1:0] ch_hit, mask, pend, irq_prev, set, clr, masked, pend_next;
  logic                is_mask, is_pend, is_vec, any, in_irq;
  logic [2:0]          idx;
  logic [DATA_W-1:0]   vec, rdata, in_data;
  logic                unused;
  assign unused  = ^{bus.read_strobe, bus.out_port};
  assign is_mask = bus.port_id == CTRL_BASE;
  assign is_pend = bus.port_id == CTRL_BASE + ADDR_W'(1);
  assign is_vec  = bus.port_id == CTRL_BASE + ADDR_W'(2);
  assign ch_addr = bus.port_id[SHIFT-1:0];
  for (genvar c = 0; c < N_PERIPH; c++) begin : g_dec
    assign ch_hit[c] = !(is_mask || is_pend || is_vec) && (bus.port_id >> SHIFT) == ADDR_W'(c);
  end
  assign ch_wr = bus.write_strobe ? ch_hit : '0;
`ifdef IO_FABRIC_RDPULSE_EN
  assign ch_rd = bus.read_strobe ? ch_hit : '0;
`else
  assign ch_rd = '0;
`endif
  assign masked = pend & mask;
  assign any    = |masked;
  always_comb begin
    idx = '0;
    for (int c = N_PERIPH - 1; c >= 0; c--)
      if (masked[c]) idx = 3'(c);
  end
  always_comb begin
    vec      = '0;
    vec[7]   = any;
    vec[2:0] = idx;
  end
  // a fresh edge re-arms a bit even if the same bit is being cleared this cycle
  assign set       = ch_irq & ~irq_prev;
  assign clr       = (bus.write_strobe && is_pend ? bus.out_port[N_PERIPH-1:0] : '0)
                   | (bus.interrupt_ack && any ? N_PERIPH'(1) << idx : '0);
  assign pend_next = (pend & ~clr) | set;
  always_comb begin
    rdata = '0;
    for (int c = 0; c < N_PERIPH; c++)
      if (ch_hit[c]) rdata = ch_rdata[c*DATA_W +: DATA_W];
    rdata = is_mask ? DATA_W'(mask) : is_pend ? DATA_W'(pend) : is_vec ? vec : rdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_data  <= '0;
      in_irq   <= 1'b0;
      mask     <= '0;
      pend     <= '0;
      irq_prev <= '1;
    end else begin
      in_data  <= rdata;
      in_irq   <= |(pend_next & mask);
      pend     <= pend_next;
      irq_prev <= ch_irq;
      if (bus.write_strobe && is_mask) mask <= bus.out_port[N_PERIPH-1:0];
    end
  end
  assign bus.in_port   = in_data;
  assign bus.interrupt = in_irq;
endmodule

// File: tb/tb_io_bus_fabric.sv
// tb_io_bus_fabric: directed checks of decode, read path, interrupt logic and optional read strobes.
module tb_io_bus_fabric;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_addr, ch_wr, ch_rd, ch_irq;
  logic [31:0] ch_rdata;
  logic [7:0]  d;
  int          passed = 0, total = 0;
  io_bus_fabric_if bus ();
  io_bus_fabric dut (
    .clk(clk), .reset(reset), .bus(bus), .ch_addr(ch_addr), .ch_wr(ch_wr), .ch_rd(ch_rd),
    .ch_rdata(ch_rdata), .ch_irq(ch_irq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    bus.port_id = a; bus.out_port = v; bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    bus.port_id = a;
    tick();
    v = bus.in_port;
  endtask
  task automatic test_reset();
    reset = 1'b0; ch_irq = '0; ch_rdata = 32'h4433_3C11;
    bus.port_id = 8'h1F; bus.out_port = '0; bus.write_strobe = 0; bus.read_strobe = 0;
    bus.interrupt_ack = 0;
    tick(); tick();
    total++; if (bus.in_port !== 8'h00) $display("FAIL reset_in_port got %h exp 00", bus.in_port); else passed++;
    total++; if (bus.interrupt !== 1'b0) $display("FAIL reset_irq got %b exp 0", bus.interrupt); else passed++;
    reset = 1'b1;
    rd(8'hF0, d);
    total++; if (d !== 8'h00) $display("FAIL reset_mask got %h exp 00", d); else passed++;
    rd(8'hF1, d);
    total++; if (d !== 8'h00) $display("FAIL reset_pend got %h exp 00", d); else passed++;
  endtask
  task automatic test_write();
    bus.port_id = 8'h23; bus.out_port = 8'hA5;
    #1;
    total++; if (ch_wr !== 4'b0000) $display("FAIL wr_idle got %b exp 0000", ch_wr); else passed++;
    bus.write_strobe = 1'b1;
    #1;
    total++; if (ch_wr !== 4'b0100) $display("FAIL wr_decode got %b exp 0100", ch_wr); else passed++;
    total++; if (ch_addr !== 4'h3) $display("FAIL wr_addr got %h exp 3", ch_addr); else passed++;
    tick();
    bus.write_strobe = 1'b0;
    #1;
    total++; if (ch_wr !== 4'b0000) $display("FAIL wr_after got %b exp 0000", ch_wr); else passed++;
    bus.port_id = 8'hF0; bus.out_port = 8'h00; bus.write_strobe = 1'b1;
    #1;
    total++; if (ch_wr !== 4'b0000) $display("FAIL wr_ctrl got %b exp 0000", ch_wr); else passed++;
    tick();
    bus.write_strobe = 1'b0;
  endtask
  task automatic test_read();
    rd(8'h1F, d);
    total++; if (d !== 8'h3C) $display("FAIL rd_ch1_c1 got %h exp 3c", d); else passed++;
    rd(8'h1F, d);
    total++; if (d !== 8'h3C) $display("FAIL rd_ch1_c2 got %h exp 3c", d); else passed++;
    rd(8'h77, d);
    total++; if (d !== 8'h00) $display("FAIL rd_unmapped got %h exp 00", d); else passed++;
    rd(8'h3F, d);
    total++; if (d !== 8'h44) $display("FAIL rd_ch3 got %h exp 44", d); else passed++;
  endtask
  task automatic test_priority();
    wr(8'hF0, 8'h0A);
    ch_irq = 4'b1000; tick(); ch_irq = 4'b0000;
    total++; if (bus.interrupt !== 1'b1) $display("FAIL pri_irq3 got %b exp 1", bus.interrupt); else passed++;
    tick();
    ch_irq = 4'b0010; tick(); ch_irq = 4'b0000;
    rd(8'hF2, d);
    total++; if (d !== 8'h81) $display("FAIL pri_vec1 got %h exp 81", d); else passed++;
    bus.interrupt_ack = 1'b1; tick(); bus.interrupt_ack = 1'b0;
    rd(8'hF2, d);
    total++; if (d !== 8'h83) $display("FAIL pri_vec3 got %h exp 83", d); else passed++;
    total++; if (bus.interrupt !== 1'b1) $display("FAIL pri_hold got %b exp 1", bus.interrupt); else passed++;
    bus.interrupt_ack = 1'b1; tick(); bus.interrupt_ack = 1'b0;
    total++; if (bus.interrupt !== 1'b0) $display("FAIL pri_drop got %b exp 0", bus.interrupt); else passed++;
    rd(8'hF2, d);
    total++; if (d !== 8'h00) $display("FAIL pri_vec0 got %h exp 00", d); else passed++;
  endtask
  task automatic test_masked();
    wr(8'hF0, 8'h00);
    ch_irq = 4'b0001; tick(); ch_irq = 4'b0000; tick();
    total++; if (bus.interrupt !== 1'b0) $display("FAIL msk_quiet got %b exp 0", bus.interrupt); else passed++;
    rd(8'hF1, d);
    total++; if (d !== 8'h01) $display("FAIL msk_pend got %h exp 01", d); else passed++;
    wr(8'hF0, 8'h01); tick();
    total++; if (bus.interrupt !== 1'b1) $display("FAIL msk_fire got %b exp 1", bus.interrupt); else passed++;
    wr(8'hF1, 8'h01);
    total++; if (bus.interrupt !== 1'b0) $display("FAIL msk_w1c_irq got %b exp 0", bus.interrupt); else passed++;
    rd(8'hF1, d);
    total++; if (d !== 8'h00) $display("FAIL msk_w1c got %h exp 00", d); else passed++;
  endtask
  task automatic test_set_wins();
    wr(8'hF0, 8'h04);
    ch_irq = 4'b0100; tick(); ch_irq = 4'b0000; tick();
    ch_irq = 4'b0100; bus.interrupt_ack = 1'b1; tick();
    ch_irq = 4'b0000; bus.interrupt_ack = 1'b0;
    rd(8'hF1, d);
    total++; if (d !== 8'h04) $display("FAIL setwin_pend got %h exp 04", d); else passed++;
    wr(8'hF1, 8'h0F);
    wr(8'hF0, 8'h06);
    ch_irq = 4'b0110; tick(); ch_irq = 4'b0000;
    bus.port_id = 8'hF1; bus.out_port = 8'h04; bus.write_strobe = 1'b1; bus.interrupt_ack = 1'b1;
    tick();
    bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    rd(8'hF1, d);
    total++; if (d !== 8'h00) $display("FAIL ack_w1c got %h exp 00", d); else passed++;
    bus.interrupt_ack = 1'b1; tick(); bus.interrupt_ack = 1'b0;
    rd(8'hF1, d);
    total++; if (d !== 8'h00) $display("FAIL ack_idle got %h exp 00", d); else passed++;
  endtask
  task automatic test_reset_mid();
    rd(8'h1F, d);
    reset = 1'b0;
    #1;
    total++; if (bus.in_port !== 8'h00) $display("FAIL async_rst got %h exp 00", bus.in_port); else passed++;
    ch_irq = 4'b0100; tick(); reset = 1'b1; tick(); tick();
    total++; if (bus.interrupt !== 1'b0) $display("FAIL hold_irq got %b exp 0", bus.interrupt); else passed++;
    rd(8'hF1, d);
    total++; if (d !== 8'h00) $display("FAIL hold_pend got %h exp 00", d); else passed++;
    ch_irq = 4'b0000;
  endtask
  task automatic test_rdpulse();
    logic [3:0] exp_rd;
`ifdef IO_FABRIC_RDPULSE_EN
    exp_rd = 4'b0001;
`else
    exp_rd = 4'b0000;
`endif
    bus.port_id = 8'h05; bus.read_strobe = 1'b1;
    #1;
    total++; if (ch_rd !== exp_rd) $display("FAIL rdpulse got %b exp %b", ch_rd, exp_rd); else passed++;
    tick();
    total++; if (bus.in_port !== 8'h11) $display("FAIL rdpulse_data got %h exp 11", bus.in_port); else passed++;
    bus.read_strobe = 1'b0;
    #1;
    total++; if (ch_rd !== 4'b0000) $display("FAIL rdpulse_off got %b exp 0000", ch_rd); else passed++;
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_masked();
    test_set_wins();
    test_reset_mid();
    test_rdpulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
